fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Stage 0/F instruction fetch unit. Holds the architectural fetch PC and issues requests to the instruction cache.
- Captures returned instructions and presents pc/inst to the stage-1/I decode and transfer logic.
- Handles downstream stalls, cache-miss stalls and branch/jump redirects from stage 2/X. Redirects flush in-flight fetches to NOP.

Parameters:
- RESET_PC, 32'h0000_2000, first fetch address after reset release
- NOP_INST, 32'h0000_0013, instruction driven on inst_out when no valid instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  downstream (stage 1/I) stall; outputs must hold
- redirect_valid  in  1  stage 2/X requests fetch restart
- redirect_pc  in  32  restart target (bits [1:0] are zero)
- icache_re  out  1  fetch request
- icache_addr  out  32  fetch address
- icache_dout  in  32  instruction data; valid the cycle after a request cycle in which icache_stall=0
- icache_stall  in  1  cache busy/miss; request must stay stable while high
- pc_out  out  32  PC of inst_out
- inst_out  out  32  fetched instruction, or NOP_INST
- inst_valid  out  1  inst_out is a real instruction

Behaviour:
- Reset (reset low, asynchronous):
  - fetch_pc=RESET_PC, state=FETCH, pc_out=0, inst_out=NOP_INST, inst_valid=0.
  - icache_re=0 while reset is low. The first request at RESET_PC goes out in the first cycle after release.
- Request protocol:
  - A request cycle has icache_re=1, icache_addr=fetch_pc.
  - If icache_stall=0 in that cycle, data returns the next cycle on icache_dout.
  - If icache_stall=1, icache_re and icache_addr are held unchanged until the cycle in which icache_stall=0.
- States:
  - FETCH:
    - Request outstanding or being issued.
    - On response with stall=0: register pc_out=resp_pc, inst_out=icache_dout, inst_valid=1. Issue next request at resp_pc+4 the same cycle (pipelined, 1 instr/cycle).
    - On response with stall=1: buffer the response in a skid register and go to HOLD. No new request.
  - HOLD:
    - Outputs unchanged; icache_re=0.
    - When stall falls: move the buffered instruction to the outputs, request buffered_pc+4, go to FETCH.
  - KILL:
    - A redirect arrived while a request was stalled in the cache.
    - Keep icache_re and icache_addr stable until icache_stall=0. Discard that response.
    - Then request pending_pc and go to FETCH.
- Latency: request-to-inst_out is 1 cycle with no miss; throughput is 1 instr/cycle.
- Redirect (highest priority, wins over stall, response capture and HOLD):
  - Next edge: inst_out=NOP_INST, inst_valid=0, pc_out=redirect_pc. The skid buffer is cleared.
  - If no cache request is stuck (icache_stall=0): request redirect_pc next cycle; any response returning for the old pc is dropped.
  - If icache_stall=1: store pending_pc=redirect_pc and go to KILL.
  - A second redirect while in KILL overwrites pending_pc.
- Simultaneous stall and redirect: the redirect is taken; the flush NOP stays on the outputs while stall remains high.
- Outputs while stall=1 and no redirect: pc_out, inst_out and inst_valid stay bit-identical.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset mid-miss or mid-HOLD: all state is discarded immediately. After release, fetch restarts at RESET_PC regardless of icache_stall history.

Test Plan:
- Reset release, icache_stall=0, stall=0, dout=mem[pc] -> inst_out sequence for pc 2000,2004,2008 on consecutive cycles, inst_valid=1 from the 2nd cycle after release.
- icache_stall high 3 cycles on the request to 2004 -> icache_addr held at 2004 for all 4 cycles, inst_out holds the 2000 instruction, then 2004 appears.
- stall=1 for 2 cycles while the response for 2008 returns -> outputs frozen at 2004; icache_re=0 in HOLD; 2008 appears on the first cycle after stall falls, and the next request is to 200C.
- redirect_valid with redirect_pc=3000 on a normal cycle -> next edge inst_valid=0, inst_out=00000013; the next request is 3000 and the old 2008 response is never output.
- redirect to 4000 during a miss on 2010 -> addr held at 2010 until icache_stall falls, that data dropped, then request 4000 and inst 4000 becomes valid.
- fetch_pc 32'hFFFF_FFFC -> next request address 32'h0000_0000; assert reset low mid-miss -> outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction cache request/response bus between fetch and icache
interface fetch_unit_if;
    logic        icache_re;
    logic [31:0] icache_addr;
    logic [31:0] icache_dout;
    logic        icache_stall;

    modport master (
        output icache_re,
        output icache_addr,
        input  icache_dout,
        input  icache_stall
    );

    modport slave (
        input  icache_re,
        input  icache_addr,
        output icache_dout,
        output icache_stall
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - stage F instruction fetch unit
// Pipelined icache requests, downstream skid buffer, redirect flush with kill of stuck requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       icache,
    output logic [31:0]        pc_out,
    output logic [31:0]        inst_out,
    output logic               inst_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic        resp_valid, resp_valid_d;
    logic [31:0] resp_pc, resp_pc_d;
    logic [31:0] skid_pc, skid_pc_d;
    logic [31:0] skid_inst, skid_inst_d;
    logic [31:0] pending_pc, pending_pc_d;
    logic [31:0] pc_out_d;
    logic [31:0] inst_out_d;
    logic        inst_valid_d;
    logic        req;
    logic        accept;

    // A response blocked by a downstream stall suppresses the next request;
    // KILL keeps the stuck request asserted until the cache lets it go.
    always_comb begin
        req = 1'b0;
        if (reset) begin
            case (state)
                FETCH:   req = !(resp_valid && stall);
                KILL:    req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    assign accept             = req && !icache.icache_stall;
    assign icache.icache_re   = req;
    assign icache.icache_addr = fetch_pc;

    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc;
        skid_pc_d    = skid_pc;
        skid_inst_d  = skid_inst;
        pending_pc_d = pending_pc;
        pc_out_d     = pc_out;
        inst_out_d   = inst_out;
        inst_valid_d = inst_valid;

        if (redirect_valid) begin
            pc_out_d     = redirect_pc;
            inst_out_d   = NOP_INST;
            inst_valid_d = 1'b0;
            skid_pc_d    = 32'h0;
            skid_inst_d  = NOP_INST;
            if (req && icache.icache_stall) begin
                // The stuck request cannot be withdrawn; let it finish and drop it.
                state_d      = KILL;
                pending_pc_d = redirect_pc;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = redirect_pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (resp_valid && stall) begin
                        skid_pc_d   = resp_pc;
                        skid_inst_d = icache.icache_dout;
                        state_d     = HOLD;
                    end else if (resp_valid) begin
                        pc_out_d     = resp_pc;
                        inst_out_d   = icache.icache_dout;
                        inst_valid_d = 1'b1;
                    end
                    if (accept) begin
                        resp_valid_d = 1'b1;
                        resp_pc_d    = fetch_pc;
                        fetch_pc_d   = fetch_pc + 32'd4;
                    end
                end
                HOLD: begin
                    // fetch_pc already points at skid_pc + 4
                    if (!stall) begin
                        pc_out_d     = skid_pc;
                        inst_out_d   = skid_inst;
                        inst_valid_d = 1'b1;
                        state_d      = FETCH;
                    end
                end
                KILL: begin
                    if (!icache.icache_stall) begin
                        fetch_pc_d = pending_pc;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'h0;
            skid_pc    <= 32'h0;
            skid_inst  <= NOP_INST;
            pending_pc <= 32'h0;
            pc_out     <= 32'h0;
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_d;
            fetch_pc   <= fetch_pc_d;
            resp_valid <= resp_valid_d;
            resp_pc    <= resp_pc_d;
            skid_pc    <= skid_pc_d;
            skid_inst  <= skid_inst_d;
            pending_pc <= pending_pc_d;
            pc_out     <= pc_out_d;
            inst_out   <= inst_out_d;
            inst_valid <= inst_valid_d;
        end
    end

endmodule
